// File: rtl/hex_pkg.sv
// Shared constants for the 7-segment character link: active-low segment patterns,
// character codes and the receive-side handshake FSM state type.
package hex_pkg;

    // Active-low segment patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] PAT_P     = 7'h0C;
    localparam logic [6:0] PAT_A     = 7'h08;
    localparam logic [6:0] PAT_S     = 7'h12;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    localparam logic [2:0] CODE_P     = 3'b000;
    localparam logic [2:0] CODE_A     = 3'b001;
    localparam logic [2:0] CODE_S     = 3'b010;
    localparam logic [2:0] CODE_2     = 3'b011;
    localparam logic [2:0] CODE_4     = 3'b100;
    localparam logic [2:0] CODE_1     = 3'b101;
    localparam logic [2:0] CODE_BLANK = 3'b110;
    // The encoder also blanks on this code; the decoder uses it only for unknown patterns.
    localparam logic [2:0] CODE_ERR   = 3'b111;

    typedef enum logic {
        StIdle,
        StPend
    } dec_state_e;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational table decode of an active-low 7-segment pattern into a character code
// plus error and blank flags.
module seg7_to_code
    import hex_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [2:0] code_o,
    output logic       err_o,
    output logic       blank_o
);

    always_comb begin
        code_o  = CODE_ERR;
        err_o   = 1'b0;
        blank_o = 1'b0;
        case (pat_i)
            PAT_P:     code_o = CODE_P;
            PAT_A:     code_o = CODE_A;
            PAT_S:     code_o = CODE_S;
            PAT_2:     code_o = CODE_2;
            PAT_4:     code_o = CODE_4;
            PAT_1:     code_o = CODE_1;
            PAT_BLANK: begin
                code_o  = CODE_BLANK;
                blank_o = 1'b1;
            end
            default: begin
                code_o = CODE_ERR;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/hex_pattern_decoder.sv
// Receive side of the 7-segment character link: synchronise, debounce and decode the
// segment bus, then hand each newly accepted character downstream over valid/ready.
module hex_pattern_decoder
    import hex_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [6:0]       HEX_in,
    output logic [2:0]       code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             code_err,
    output logic             code_blank,
    output logic             overrun,
    output logic [CNT_W-1:0] char_count
);

    localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

    logic [6:0]       sync1_q, sync1_d;
    logic [6:0]       sync2_q, sync2_d;
    logic [6:0]       prev_q, prev_d;
    logic [6:0]       last_q, last_d;
    logic [3:0]       stab_q, stab_d;
    logic [2:0]       code_q, code_d;
    logic             err_q, err_d;
    logic             blank_q, blank_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] count_q, count_d;
    dec_state_e       state_q, state_d;

    logic             accept;
    logic [2:0]       dec_code;
    logic             dec_err;
    logic             dec_blank;

    seg7_to_code u_seg7_to_code (
        .pat_i   (sync2_q),
        .code_o  (dec_code),
        .err_o   (dec_err),
        .blank_o (dec_blank)
    );

    // Synchroniser, run-length counter and accept detection.
    always_comb begin
        sync1_d = HEX_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        stab_d  = 4'd1;
        if (sync2_q == prev_q) begin
            stab_d = (stab_q == StableMax) ? stab_q : stab_q + 4'd1;
        end
        // Fire only on the cycle the run reaches the threshold, never while it sits there.
        accept = (stab_d == StableMax) && (stab_q != StableMax) && (sync2_q != last_q);
    end

    // Handshake FSM, output registers and character counter.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        err_d     = err_q;
        blank_d   = blank_q;
        last_d    = last_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (accept) begin
            code_d  = dec_code;
            err_d   = dec_err;
            blank_d = dec_blank;
            last_d  = sync2_q;
            count_d = count_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (accept) begin
                    state_d = StPend;
                    if (!code_ready) begin
                        overrun_d = 1'b1;
                    end
                end else if (code_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= PAT_BLANK;
            sync2_q   <= PAT_BLANK;
            prev_q    <= PAT_BLANK;
            last_q    <= PAT_BLANK;
            stab_q    <= 4'd0;
            code_q    <= CODE_BLANK;
            err_q     <= 1'b0;
            blank_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            state_q   <= StIdle;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            last_q    <= last_d;
            stab_q    <= stab_d;
            code_q    <= code_d;
            err_q     <= err_d;
            blank_q   <= blank_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    assign code       = code_q;
    assign code_err   = err_q;
    assign code_blank = blank_q;
    assign code_valid = (state_q == StPend);
    assign overrun    = overrun_q;
    assign char_count = count_q;

endmodule

// File: tb/tb_hex_pattern_decoder.sv
// Scoreboard bench for hex_pattern_decoder: stimulus pushes expected characters with their
// handshake cycle, a negedge monitor pops and compares on every valid && ready.
module tb_hex_pattern_decoder;

    logic       clk;
    logic       resetn;
    logic [6:0] hex_in;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       code_err;
    logic       code_blank;
    logic       overrun;
    logic [7:0] char_count;

    int checks;
    int failures;
    int cyc;
    int exp_count;
    int valid_seen;

    typedef struct {
        logic [2:0] code;
        logic       err;
        logic       blank;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    hex_pattern_decoder #(
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .HEX_in     (hex_in),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_err   (code_err),
        .code_blank (code_blank),
        .overrun    (overrun),
        .char_count (char_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a pattern and, if it should be handed off, queue its expected response.
    task automatic send(input logic [6:0] pat, input logic [2:0] c, input logic e,
                        input logic b, input bit expect_hs);
        exp_t item;
        hex_in = pat;
        exp_count++;
        if (expect_hs) begin
            item.code  = c;
            item.err   = e;
            item.blank = b;
            item.cyc   = cyc + 6;
            sb_q.push_back(item);
        end
    endtask

    // Monitor: every handshake must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && code_valid && code_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got code %0d with empty queue (cycle %0d)",
                             code, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("hs_data", int'({code, code_err, code_blank}),
                          int'({e.code, e.err, e.blank}));
                    if (e.cyc >= 0) check("hs_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        exp_t item;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        exp_count  = 0;
        resetn     = 1'b0;
        hex_in     = 7'h7F;
        code_ready = 1'b1;
        tick(3);
        check("reset_code", int'(code), 6);
        check("reset_valid", int'(code_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        resetn = 1'b1;

        // Blank after reset must never produce a character.
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (code_valid) valid_seen++;
        end
        check("blank_no_valid", valid_seen, 0);
        check("blank_count", int'(char_count), 0);
        check("blank_code", int'(code), 6);

        // Clean change to 'A' with ready high: one-cycle valid, 6 cycles later.
        send(7'h08, 3'b001, 1'b0, 1'b0, 1'b1);
        tick(8);
        check("a_count", int'(char_count), exp_count);
        check("a_valid_dropped", int'(code_valid), 0);

        // Short glitch then return to last accepted: nothing accepted.
        hex_in = 7'h12;
        tick(3);
        hex_in = 7'h08;
        tick(10);
        check("glitch_count", int'(char_count), exp_count);

        // Overrun: two characters while the consumer stalls.
        code_ready = 1'b0;
        send(7'h24, 3'b011, 1'b0, 1'b0, 1'b0);
        tick(8);
        check("stall_valid", int'(code_valid), 1);
        check("stall_code", int'(code), 3);
        check("stall_overrun", int'(overrun), 0);
        tick(2);
        send(7'h79, 3'b101, 1'b0, 1'b0, 1'b0);
        tick(8);
        check("ovr_code", int'(code), 5);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid", int'(code_valid), 1);
        check("ovr_count", int'(char_count), exp_count);
        item.code  = 3'b101;
        item.err   = 1'b0;
        item.blank = 1'b0;
        item.cyc   = -1;
        sb_q.push_back(item);
        code_ready = 1'b1;
        tick(1);
        check("ovr_released", int'(code_valid), 0);
        check("ovr_sticky", int'(overrun), 1);

        // Unknown pattern, then blank.
        send(7'h55, 3'b111, 1'b1, 1'b0, 1'b1);
        tick(8);
        send(7'h7F, 3'b110, 1'b0, 1'b1, 1'b1);
        tick(8);
        check("err_blank_count", int'(char_count), exp_count);

        // Fresh start, then 256 accepts must wrap the counter to zero.
        resetn = 1'b0;
        #2;
        resetn    = 1'b1;
        exp_count = 0;
        tick(6);
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) send(7'h0C, 3'b000, 1'b0, 1'b0, 1'b1);
            else            send(7'h08, 3'b001, 1'b0, 1'b0, 1'b1);
            tick(7);
        end
        check("wrap_count", int'(char_count), exp_count % 256);
        check("wrap_count_zero", int'(char_count), 0);

        // Reset asserted while a character is pending clears everything at once.
        code_ready = 1'b0;
        send(7'h24, 3'b011, 1'b0, 1'b0, 1'b0);
        tick(7);
        check("pend_valid", int'(code_valid), 1);
        #2;
        resetn = 1'b0;
        hex_in = 7'h7F;
        #1;
        check("mid_reset_valid", int'(code_valid), 0);
        check("mid_reset_code", int'(code), 6);
        check("mid_reset_flags", int'({code_err, code_blank, overrun}), 0);
        check("mid_reset_count", int'(char_count), 0);
        tick(2);
        resetn     = 1'b1;
        code_ready = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (code_valid) valid_seen++;
        end
        check("post_reset_no_valid", valid_seen, 0);
        check("post_reset_count", int'(char_count), 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
